prog_ctr: RTL and testbench

PROG_CTR -- requirements
Module: prog_ctr

---
 rtl/prog_ctr_pkg.sv | 20 ++
 rtl/prog_ctr_if.sv | 29 ++
 rtl/prog_ctr_branch_lut.sv | 20 ++
 rtl/prog_ctr.sv | 98 +++++++++
 tb/tb_prog_ctr.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_ctr_pkg.sv
// Shared types and default sizes for the program counter block.
// The branch-target table contents are defined here so every user agrees on them.
package prog_ctr_pkg;

    localparam int PC_W_DEF   = 10;
    localparam int LUT_AW_DEF = 5;
    localparam int ICNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Entry i of the branch-target table points at address (i+1)*16.
    function automatic int lutTarget(input int idx);
        return (idx + 1) * 16;
    endfunction

endpackage

// File: rtl/prog_ctr_if.sv
// Decoder/ALU flags into the program counter and its registered status back out.
interface prog_ctr_if
    import prog_ctr_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int LUT_AW = LUT_AW_DEF
);

    logic              start;
    logic              halt;
    logic              jump;
    logic              branch;
    logic              zero;
    logic [LUT_AW-1:0] targetIdx;
    logic [PC_W-1:0]   pc;
    logic              done;
    logic [ICNT_W-1:0] instCount;

    modport master (
        output start, halt, jump, branch, zero, targetIdx,
        input  pc, done, instCount
    );

    modport slave (
        input  start, halt, jump, branch, zero, targetIdx,
        output pc, done, instCount
    );

endinterface

// File: rtl/prog_ctr_branch_lut.sv
// Fixed branch/jump target table, read combinationally by index.
module branch_lut
    import prog_ctr_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int LUT_AW = LUT_AW_DEF
) (
    input  logic [LUT_AW-1:0] idx_i,
    output logic [PC_W-1:0]   target_o
);

    logic [PC_W-1:0] table_w [2**LUT_AW];

    for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_entry
        assign table_w[i] = PC_W'(lutTarget(i));
    end

    assign target_o = table_w[idx_i];

endmodule

// File: rtl/prog_ctr.sv
// Program counter sequencer: IDLE/RUN/DONE control, next-PC selection
// and a saturating retired-instruction counter, all outputs registered.
module prog_ctr
    import prog_ctr_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int LUT_AW = LUT_AW_DEF
) (
    input  logic      clk_i,
    input  logic      reset_i,
    prog_ctr_if.slave ctrl
);

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic                done_q, done_d;
    logic [ICNT_W-1:0]   instCount_q, instCount_d;
    logic                start_q;
    logic [PC_W-1:0]     lutTarget_w;

    branch_lut #(
        .PC_W   (PC_W),
        .LUT_AW (LUT_AW)
    ) u_lut (
        .idx_i    (ctrl.targetIdx),
        .target_o (lutTarget_w)
    );

    // Start has priority over the decoder flags while running: it aborts the run.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        done_d      = done_q;
        instCount_d = instCount_q;
        unique case (state_q)
            IDLE: begin
                pc_d   = '0;
                done_d = 1'b0;
                if (start_q && !ctrl.start) begin
                    state_d     = RUN;
                    instCount_d = '0;
                end
            end
            RUN: begin
                if (ctrl.start) begin
                    state_d = IDLE;
                    pc_d    = '0;
                end else begin
                    if (instCount_q != '1) begin
                        instCount_d = instCount_q + ICNT_W'(1);
                    end
                    if (ctrl.halt) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (ctrl.jump || (ctrl.branch && !ctrl.zero)) begin
                        pc_d = lutTarget_w;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            DONE: begin
                done_d = 1'b1;
                if (ctrl.start) begin
                    state_d = IDLE;
                    pc_d    = '0;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            done_q      <= 1'b0;
            instCount_q <= '0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            done_q      <= done_d;
            instCount_q <= instCount_d;
            start_q     <= ctrl.start;
        end
    end

    assign ctrl.pc        = pc_q;
    assign ctrl.done      = done_q;
    assign ctrl.instCount = instCount_q;

endmodule

// File: tb/tb_prog_ctr.sv
// Self-checking bench for prog_ctr: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the sequencer.
module tb_prog_ctr;

    localparam int PC_W   = 10;
    localparam int LUT_AW = 5;
    localparam int PC_MOD = 1 << PC_W;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    prog_ctr_if #(.PC_W(PC_W), .LUT_AW(LUT_AW)) bus();

    prog_ctr #(
        .PC_W   (PC_W),
        .LUT_AW (LUT_AW)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .ctrl    (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: running/halted flags, PC value, retired count.
    int mPc;
    int mCount;
    bit mRunning;
    bit mHalted;
    bit mPrevStart;
    int lutRef [32];

    task automatic setIn(input bit s, input bit h, input bit j, input bit b,
                         input bit z, input int idx);
        bus.start     = s;
        bus.halt      = h;
        bus.jump      = j;
        bus.branch    = b;
        bus.zero      = z;
        bus.targetIdx = LUT_AW'(idx);
    endtask

    // Advance the model by the rules for the inputs now applied, then clock the DUT.
    task automatic tick();
        if (reset) begin
            mRunning = 0; mHalted = 0; mPc = 0; mCount = 0; mPrevStart = 0;
        end else begin
            if (mRunning) begin
                if (bus.start) begin
                    mRunning = 0;
                    mPc = 0;
                end else begin
                    if (mCount < 65535) mCount++;
                    if (bus.halt) begin
                        mRunning = 0;
                        mHalted = 1;
                    end else if (bus.jump || (bus.branch && !bus.zero)) begin
                        mPc = lutRef[bus.targetIdx];
                    end else begin
                        mPc = (mPc + 1) % PC_MOD;
                    end
                end
            end else if (mHalted) begin
                if (bus.start) begin
                    mHalted = 0;
                    mPc = 0;
                end
            end else if (mPrevStart && !bus.start) begin
                mRunning = 1;
                mCount = 0;
            end
            mPrevStart = bus.start;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        setIn(1, 1, 1, 1, 0, 3);
        tick();
        tick();
        checks++;
        if (bus.pc !== 10'h000 || bus.done !== 1'b0 || bus.instCount !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_state: pc=%0h done=%0b cnt=%0h expected 0/0/0",
                     bus.pc, bus.done, bus.instCount);
        end
        reset = 1'b0;
        setIn(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checks++;
        if (bus.pc !== 10'h000 || bus.instCount !== 16'h0000 || bus.done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_start_q: pc=%0h cnt=%0h expected still idle at 0",
                     bus.pc, bus.instCount);
        end
    endtask

    task automatic test_sequential();
        setIn(1, 0, 0, 0, 0, 0);
        tick();
        setIn(0, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (bus.pc !== 10'h000 || bus.instCount !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL run_entry: pc=%0h cnt=%0h expected 0/0", bus.pc, bus.instCount);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (bus.pc !== PC_W'(k) || bus.instCount !== 16'(k)) begin
                failures++;
                $display("[TB] FAIL seq_step%0d: pc=%0h cnt=%0h expected %0h/%0h",
                         k, bus.pc, bus.instCount, k, k);
            end
        end
    endtask

    task automatic test_branch();
        tick();
        tick();
        checks++;
        if (bus.pc !== 10'h007) begin
            failures++;
            $display("[TB] FAIL branch_setup: pc=%0h expected 7", bus.pc);
        end
        setIn(0, 0, 0, 1, 0, 3);
        tick();
        checks++;
        if (bus.pc !== 10'h040 || bus.instCount !== 16'd8) begin
            failures++;
            $display("[TB] FAIL branch_taken: pc=%0h cnt=%0h expected 40/8", bus.pc, bus.instCount);
        end
        setIn(1, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (bus.pc !== 10'h000 || bus.instCount !== 16'd8 || bus.done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort: pc=%0h cnt=%0h expected 0/8", bus.pc, bus.instCount);
        end
        setIn(0, 0, 0, 0, 0, 0);
        tick();
        for (int k = 0; k < 7; k++) tick();
        setIn(0, 0, 0, 1, 1, 3);
        tick();
        checks++;
        if (bus.pc !== 10'h008) begin
            failures++;
            $display("[TB] FAIL branch_not_taken: pc=%0h expected 8", bus.pc);
        end
        setIn(0, 0, 1, 0, 1, 5);
        tick();
        checks++;
        if (bus.pc !== 10'h060 || bus.pc !== PC_W'(mPc)) begin
            failures++;
            $display("[TB] FAIL jump: pc=%0h expected 60", bus.pc);
        end
    endtask

    task automatic test_priority();
        int pcBefore;
        int cntBefore;
        pcBefore  = mPc;
        cntBefore = mCount;
        setIn(0, 1, 1, 1, 0, 2);
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.pc !== PC_W'(pcBefore) || bus.instCount !== 16'(cntBefore + 1)) begin
            failures++;
            $display("[TB] FAIL priority_halt: done=%0b pc=%0h cnt=%0h expected 1/%0h/%0h",
                     bus.done, bus.pc, bus.instCount, pcBefore, cntBefore + 1);
        end
        for (int k = 0; k < 4; k++) begin
            setIn(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 31)));
            tick();
            checks++;
            if (bus.done !== 1'b1 || bus.pc !== PC_W'(pcBefore) || bus.instCount !== 16'(cntBefore + 1)) begin
                failures++;
                $display("[TB] FAIL done_hold%0d: done=%0b pc=%0h cnt=%0h", k, bus.done, bus.pc, bus.instCount);
            end
        end
        setIn(1, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.pc !== 10'h000) begin
            failures++;
            $display("[TB] FAIL done_exit: done=%0b pc=%0h expected 0/0", bus.done, bus.pc);
        end
        setIn(0, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (bus.instCount !== 16'h0000 || bus.pc !== 10'h000) begin
            failures++;
            $display("[TB] FAIL restart_clear: pc=%0h cnt=%0h expected 0/0", bus.pc, bus.instCount);
        end
    endtask

    task automatic test_wrap();
        int cntBefore;
        setIn(0, 0, 1, 0, 0, 31);
        tick();
        setIn(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < PC_MOD && mPc != PC_MOD - 1; k++) tick();
        checks++;
        if (bus.pc !== 10'h3FF) begin
            failures++;
            $display("[TB] FAIL wrap_reach: pc=%0h expected 3ff", bus.pc);
        end
        cntBefore = mCount;
        tick();
        checks++;
        if (bus.pc !== 10'h000 || bus.instCount !== 16'(cntBefore + 1)) begin
            failures++;
            $display("[TB] FAIL wrap: pc=%0h cnt=%0h expected 0/%0h", bus.pc, bus.instCount, cntBefore + 1);
        end
    endtask

    task automatic test_reset_midrun();
        for (int k = 0; k < 18; k++) tick();
        checks++;
        if (bus.pc !== 10'h012) begin
            failures++;
            $display("[TB] FAIL midrun_setup: pc=%0h expected 12", bus.pc);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (bus.pc !== 10'h000 || bus.done !== 1'b0 || bus.instCount !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL midrun_reset: pc=%0h done=%0b cnt=%0h expected 0/0/0",
                     bus.pc, bus.done, bus.instCount);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (bus.pc !== 10'h000) begin
            failures++;
            $display("[TB] FAIL midrun_idle: pc=%0h expected 0", bus.pc);
        end
        setIn(1, 0, 0, 0, 0, 0);
        tick();
        setIn(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checks++;
        if (bus.pc !== 10'h001 || bus.instCount !== 16'd1) begin
            failures++;
            $display("[TB] FAIL midrun_restart: pc=%0h cnt=%0h expected 1/1", bus.pc, bus.instCount);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 63) == 0);
            setIn($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, 1'($urandom),
                  1'($urandom), 1'($urandom), int'($urandom_range(0, 31)));
            tick();
            checks++;
            if (bus.pc !== PC_W'(mPc) || bus.done !== mHalted || bus.instCount !== 16'(mCount)) begin
                failures++;
                $display("[TB] FAIL random%0d: pc=%0h done=%0b cnt=%0h expected %0h/%0b/%0h",
                         k, bus.pc, bus.done, bus.instCount, mPc, mHalted, mCount);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_saturation();
        setIn(1, 0, 0, 0, 0, 0);
        tick();
        setIn(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        for (int k = 0; k < 65540; k++) begin
            setIn(0, 0, ($urandom_range(0, 31) == 0), 1'($urandom), 1'($urandom), int'($urandom_range(0, 31)));
            tick();
        end
        checks++;
        if (bus.instCount !== 16'hFFFF || bus.pc !== PC_W'(mPc)) begin
            failures++;
            $display("[TB] FAIL saturate: cnt=%0h pc=%0h expected ffff/%0h", bus.instCount, bus.pc, mPc);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) lutRef[i] = ((i + 1) * 16) % PC_MOD;
        mPc = 0; mCount = 0; mRunning = 0; mHalted = 0; mPrevStart = 0;
        setIn(0, 0, 0, 0, 0, 0);
        $display("[TB] prog_ctr bench start");
        test_reset();
        test_sequential();
        test_branch();
        test_priority();
        test_wrap();
        test_reset_midrun();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
